// File: rtl/fpmult_norm_sched_pkg.sv
// Shared constants and types for the FP multiplier normalize/round scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Holds the datapath widths, the overflow exponent code, the normalized-field
// struct passed from stage 1 to stage 2, and the overflow test helper.
package fpmult_norm_sched_pkg;

  localparam int M_W    = 48;   // raw 24x24 significand product
  localparam int E_W    = 9;    // biased exponent sum, one guard bit above 8
  localparam int FRAC_W = 23;   // stored single-precision fraction
  localparam int Z_W    = 32;   // packed single-precision result

  localparam logic [7:0] EXP_OVF = 8'hFF;

  // Normalized fields before rounding: fraction, exponent, guard/round/sticky.
  typedef struct packed {
    logic [FRAC_W-1:0] m;
    logic [E_W-1:0]    e;
    logic              g;
    logic              r;
    logic              s;
  } norm_t;

  // Exponent 255 and anything with bit 8 set cannot be encoded as a finite
  // single-precision value.
  function automatic logic is_ovf(input logic [E_W-1:0] e);
    return e[E_W-1] | (e[7:0] == EXP_OVF);
  endfunction

endpackage

// File: rtl/fpmult_norm_stage.sv
// Combinational normalize of a 48-bit significand product into 23-bit fraction + GRS.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when the result is captured.
//
// Ports:
//   m    - raw 24x24 significand product
//   e    - biased exponent sum before normalization
//   norm - normalized fraction, adjusted exponent, guard/round/sticky bits
module fpmult_norm_stage
  import fpmult_norm_sched_pkg::*;
(
  input  logic [M_W-1:0] m,
  input  logic [E_W-1:0] e,
  output norm_t          norm
);

  always_comb begin
    norm = '0;
    if (m[M_W-1]) begin
      // Product in [2,4): the hidden one sits at bit 47, shift one extra place.
      norm.m = m[46:24];
      norm.e = e + 9'd1;
      norm.g = m[23];
      norm.r = m[22];
      norm.s = |m[21:0];
    end else begin
      // Product in [1,2): hidden one at bit 46.
      norm.m = m[45:23];
      norm.e = e;
      norm.g = m[22];
      norm.r = m[21];
      norm.s = |m[20:0];
    end
  end

endmodule

// File: rtl/fpmult_norm_sched.sv
// Two-requester round-robin front end sharing one normalize/round/pack pipeline.
// Latency: 2 cycles from accepted operand to out_valid; throughput 1 per cycle.
// Backpressure: out_valid & !out_ready freezes both stages and drops both in*_ready.
//
// Ports:
//   clk, rst                      - single clock, synchronous active-high reset
//   in{0,1}_valid / in{0,1}_ready - per-requester handshake
//   in{0,1}_m/_e/_s/_tag          - product, exponent sum, sign, opaque tag
//   out_valid / out_ready         - result handshake
//   out_z/_ovf/_id/_tag           - packed result, overflow flag, winner, tag
//
// Build option: define FPMULT_SCHED_RNE_EN for round-to-nearest-even;
// otherwise the fraction is truncated (no carry path, same latency).
module fpmult_norm_sched
  import fpmult_norm_sched_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             in0_valid,
  output logic             in0_ready,
  input  logic [M_W-1:0]   in0_m,
  input  logic [E_W-1:0]   in0_e,
  input  logic             in0_s,
  input  logic [TAG_W-1:0] in0_tag,

  input  logic             in1_valid,
  output logic             in1_ready,
  input  logic [M_W-1:0]   in1_m,
  input  logic [E_W-1:0]   in1_e,
  input  logic             in1_s,
  input  logic [TAG_W-1:0] in1_tag,

  output logic             out_valid,
  input  logic             out_ready,
  output logic [Z_W-1:0]   out_z,
  output logic             out_ovf,
  output logic             out_id,
  output logic [TAG_W-1:0] out_tag
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic             rr_last_q,  rr_last_d;   // port granted on the last transfer

  logic             s1_vld_q,   s1_vld_d;
  norm_t            s1_norm_q,  s1_norm_d;
  logic             s1_sign_q,  s1_sign_d;
  logic             s1_id_q,    s1_id_d;
  logic [TAG_W-1:0] s1_tag_q,   s1_tag_d;

  logic             out_valid_q, out_valid_d;
  logic [Z_W-1:0]   out_z_q,     out_z_d;
  logic             out_ovf_q,   out_ovf_d;
  logic             out_id_q,    out_id_d;
  logic [TAG_W-1:0] out_tag_q,   out_tag_d;

  // ---------------------------------------------------------------------------
  // Arbitration and input selection
  // ---------------------------------------------------------------------------
  logic             pipe_adv;
  logic             gnt_id;
  logic             acc;
  logic [M_W-1:0]   sel_m;
  logic [E_W-1:0]   sel_e;
  logic             sel_s;
  logic [TAG_W-1:0] sel_tag;
  norm_t            sel_norm;

  always_comb begin
    // The whole pipe moves as one; a held output blocks everything upstream,
    // even an empty stage 1, so a stalled consumer sees no new acceptances.
    pipe_adv = !out_valid_q || out_ready;

    gnt_id = 1'b0;
    if (in0_valid && in1_valid) begin
      gnt_id = ~rr_last_q;
    end else if (in1_valid) begin
      gnt_id = 1'b1;
    end

    in0_ready = !rst && pipe_adv && in0_valid && !gnt_id;
    in1_ready = !rst && pipe_adv && in1_valid &&  gnt_id;
    acc       = in0_ready || in1_ready;

    rr_last_d = acc ? gnt_id : rr_last_q;

    sel_m   = gnt_id ? in1_m   : in0_m;
    sel_e   = gnt_id ? in1_e   : in0_e;
    sel_s   = gnt_id ? in1_s   : in0_s;
    sel_tag = gnt_id ? in1_tag : in0_tag;
  end

  fpmult_norm_stage u_norm (
    .m    (sel_m),
    .e    (sel_e),
    .norm (sel_norm)
  );

  // ---------------------------------------------------------------------------
  // Stage 1: normalized fields
  // ---------------------------------------------------------------------------
  always_comb begin
    s1_vld_d  = s1_vld_q;
    s1_norm_d = s1_norm_q;
    s1_sign_d = s1_sign_q;
    s1_id_d   = s1_id_q;
    s1_tag_d  = s1_tag_q;
    if (pipe_adv) begin
      s1_vld_d = acc;
      if (acc) begin
        s1_norm_d = sel_norm;
        s1_sign_d = sel_s;
        s1_id_d   = gnt_id;
        s1_tag_d  = sel_tag;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: round, overflow check, pack
  // ---------------------------------------------------------------------------
  logic [FRAC_W-1:0] frac_rnd;
  logic [E_W-1:0]    exp_rnd;
  logic              ovf_rnd;
  logic [Z_W-1:0]    z_rnd;

`ifdef FPMULT_SCHED_RNE_EN
  logic rnd_inc;
  logic rnd_carry;

  always_comb begin
    rnd_inc = s1_norm_q.g & (s1_norm_q.r | s1_norm_q.s | s1_norm_q.m[0]);
    // A fraction of all ones rolls over to zero; the carry bumps the exponent.
    {rnd_carry, frac_rnd} = {1'b0, s1_norm_q.m} + {{FRAC_W{1'b0}}, rnd_inc};
    exp_rnd = s1_norm_q.e + {{(E_W-1){1'b0}}, rnd_carry};
  end
`else
  logic unused_grs;
  assign unused_grs = ^{s1_norm_q.g, s1_norm_q.r, s1_norm_q.s};

  always_comb begin
    frac_rnd = s1_norm_q.m;
    exp_rnd  = s1_norm_q.e;
  end
`endif

  always_comb begin
    ovf_rnd = is_ovf(exp_rnd);
    if (ovf_rnd) begin
      z_rnd = {s1_sign_q, EXP_OVF, {FRAC_W{1'b0}}};
    end else begin
      z_rnd = {s1_sign_q, exp_rnd[7:0], frac_rnd};
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_z_d     = out_z_q;
    out_ovf_d   = out_ovf_q;
    out_id_d    = out_id_q;
    out_tag_d   = out_tag_q;
    if (pipe_adv) begin
      out_valid_d = s1_vld_q;
      if (s1_vld_q) begin
        out_z_d   = z_rnd;
        out_ovf_d = ovf_rnd;
        out_id_d  = s1_id_q;
        out_tag_d = s1_tag_q;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      // Pointer says port 1 went last, so port 0 wins the first tie.
      rr_last_q   <= 1'b1;
      s1_vld_q    <= 1'b0;
      s1_norm_q   <= '0;
      s1_sign_q   <= 1'b0;
      s1_id_q     <= 1'b0;
      s1_tag_q    <= '0;
      out_valid_q <= 1'b0;
      out_z_q     <= '0;
      out_ovf_q   <= 1'b0;
      out_id_q    <= 1'b0;
      out_tag_q   <= '0;
    end else begin
      rr_last_q   <= rr_last_d;
      s1_vld_q    <= s1_vld_d;
      s1_norm_q   <= s1_norm_d;
      s1_sign_q   <= s1_sign_d;
      s1_id_q     <= s1_id_d;
      s1_tag_q    <= s1_tag_d;
      out_valid_q <= out_valid_d;
      out_z_q     <= out_z_d;
      out_ovf_q   <= out_ovf_d;
      out_id_q    <= out_id_d;
      out_tag_q   <= out_tag_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_z     = out_z_q;
  assign out_ovf   = out_ovf_q;
  assign out_id    = out_id_q;
  assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_fpmult_norm_sched.sv
// Self-checking bench for fpmult_norm_sched: directed cases plus randomized
// traffic compared every cycle against an arithmetic reference model.
// Honors FPMULT_SCHED_RNE_EN the same way the design build does.
module tb_fpmult_norm_sched;

  localparam int TAG_W = 4;

  logic             clk;
  logic             rst;
  logic             in0_valid, in0_ready, in0_s;
  logic [47:0]      in0_m;
  logic [8:0]       in0_e;
  logic [TAG_W-1:0] in0_tag;
  logic             in1_valid, in1_ready, in1_s;
  logic [47:0]      in1_m;
  logic [8:0]       in1_e;
  logic [TAG_W-1:0] in1_tag;
  logic             out_valid, out_ready, out_ovf, out_id;
  logic [31:0]      out_z;
  logic [TAG_W-1:0] out_tag;

  fpmult_norm_sched #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .in0_valid(in0_valid), .in0_ready(in0_ready), .in0_m(in0_m),
    .in0_e(in0_e), .in0_s(in0_s), .in0_tag(in0_tag),
    .in1_valid(in1_valid), .in1_ready(in1_ready), .in1_m(in1_m),
    .in1_e(in1_e), .in1_s(in1_s), .in1_tag(in1_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z),
    .out_ovf(out_ovf), .out_id(out_id), .out_tag(out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0]      z;
    logic             ovf;
    logic             id;
    logic [TAG_W-1:0] tag;
  } exp_t;

  // Reference: treat the product as an integer, shift so the 24-bit significand
  // remains, round from the discarded remainder, then pack.
  function automatic exp_t model(input logic [47:0] m, input logic [8:0] e,
                                 input logic s, input logic id, input logic [TAG_W-1:0] tag);
    exp_t r;
    longint unsigned mm, q, frac;
    int sh, ex;
    logic [63:0] fq;
    logic [31:0] exb;
    mm   = 64'(m);
    sh   = m[47] ? 24 : 23;
    q    = mm >> sh;
    frac = q & 64'h7FFFFF;
    ex   = int'(e) + (m[47] ? 1 : 0);
`ifdef FPMULT_SCHED_RNE_EN
    begin
      longint unsigned rem, half;
      logic [63:0] qb;
      rem  = mm & ((64'd1 << sh) - 1);
      half = 64'd1 << (sh - 1);
      qb   = q;
      if (rem > half || (rem == half && qb[0])) frac++;
      if (frac == 64'h800000) begin
        frac = 0;
        ex++;
      end
    end
`endif
    ex    = ex % 512;
    fq    = frac;
    exb   = ex;
    r.ovf = (ex >= 255);
    r.z   = r.ovf ? {s, 8'hFF, 23'h0} : {s, exb[7:0], fq[22:0]};
    r.id  = id;
    r.tag = tag;
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Per-cycle compare process
  // ---------------------------------------------------------------------------
  exp_t             sb[$];
  logic             rr_last = 1'b1;
  logic             rst_seen = 1'b0;
  logic             hold_vld = 1'b0;
  logic [31:0]      hold_z;
  logic [TAG_W-1:0] hold_tag;

  always @(negedge clk) begin
    logic adv, e0, e1;
    exp_t x;
    if (rst) begin
      chk("rst_ready0", in0_ready, 0);
      chk("rst_ready1", in1_ready, 0);
      sb.delete();
      rr_last  = 1'b1;
      hold_vld = 1'b0;
      rst_seen = 1'b1;
    end else begin
      if (rst_seen) chk("post_rst_out_valid", out_valid, 0);
      rst_seen = 1'b0;
      adv = !out_valid || out_ready;
      e0  = adv && in0_valid && (!in1_valid || rr_last);
      e1  = adv && in1_valid && (!in0_valid || !rr_last);
      chk("ready0", in0_ready, e0);
      chk("ready1", in1_ready, e1);
      if (hold_vld) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_z", out_z, hold_z);
        chk("stall_tag", out_tag, hold_tag);
      end
      hold_vld = 1'b0;
      if (out_valid) begin
        if (!out_ready) begin
          hold_vld = 1'b1;
          hold_z   = out_z;
          hold_tag = out_tag;
        end else if (sb.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          x = sb.pop_front();
          chk("out_z", out_z, x.z);
          chk("out_ovf", out_ovf, x.ovf);
          chk("out_id", out_id, x.id);
          chk("out_tag", out_tag, x.tag);
        end
      end
      if (in0_valid && in0_ready) begin
        sb.push_back(model(in0_m, in0_e, in0_s, 1'b0, in0_tag));
        rr_last = 1'b0;
      end else if (in1_valid && in1_ready) begin
        sb.push_back(model(in1_m, in1_e, in1_s, 1'b1, in1_tag));
        rr_last = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic run_one(input string nm, input logic [47:0] m, input logic [8:0] e,
                         input logic s, input logic [31:0] ez, input logic eovf);
    exp_t mx;
    int   n;
    mx = model(m, e, s, 1'b0, 4'h5);
    chk({nm, "_model_z"}, mx.z, ez);
    chk({nm, "_model_ovf"}, mx.ovf, eovf);
    @(posedge clk); #1;
    in0_m = m; in0_e = e; in0_s = s; in0_tag = 4'h5; in0_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in0_ready && n < 20);
    chk({nm, "_accept"}, in0_ready, 1);
    @(posedge clk); #1;
    in0_valid = 1'b0;
    @(negedge clk);
    chk({nm, "_lat1_valid"}, out_valid, 0);
    @(negedge clk);
    chk({nm, "_lat2_valid"}, out_valid, 1);
    chk({nm, "_z"}, out_z, ez);
    chk({nm, "_ovf"}, out_ovf, eovf);
    chk({nm, "_id"}, out_id, 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic rand_op(output logic [47:0] m, output logic [8:0] e, output logic s);
    logic [63:0] r;
    r = {$urandom, $urandom};
    m = r[47:0];
    case ($urandom_range(0, 3))
      0: m[47] = 1'b1;
      1: m[47:46] = 2'b01;
      2: begin m[47:46] = 2'b01; m[45:23] = '1; end
      default: begin m[47] = 1'b1; m[46:23] = '1; end
    endcase
    e = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(248, 260)) : 9'($urandom_range(0, 511));
    s = 1'($urandom);
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic       a0, a1;
    int         n, got;
    logic [3:0] ids, tags [4];
    logic [31:0] hz;
    logic [3:0]  ht;

    rst = 1'b1;
    in0_valid = 0; in0_m = '0; in0_e = '0; in0_s = 0; in0_tag = '0;
    in1_valid = 0; in1_m = '0; in1_e = '0; in1_s = 0; in1_tag = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_state", {out_valid, out_z, out_ovf, out_id, out_tag}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed arithmetic cases
    run_one("c1", 48'hC00000000000, 9'd127, 1'b0, 32'h40400000, 1'b0);
`ifdef FPMULT_SCHED_RNE_EN
    run_one("c2", 48'h400000C00000, 9'd127, 1'b0, 32'h3F800002, 1'b0);
    run_one("c3", 48'h7FFFFFC00000, 9'd127, 1'b0, 32'h40000000, 1'b0);
`else
    run_one("c2", 48'h400000C00000, 9'd127, 1'b0, 32'h3F800001, 1'b0);
    run_one("c3", 48'h7FFFFFC00000, 9'd127, 1'b0, 32'h3FFFFFFF, 1'b0);
`endif
    run_one("c4", 48'h800000000000, 9'd254, 1'b0, 32'h7F800000, 1'b1);
    run_one("c5", 48'h400000000000, 9'd10, 1'b1, 32'h85000000, 1'b0);

    // Round-robin: both ports continuously valid straight after reset
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    in0_m = 48'h400000000000; in0_e = 9'd127; in0_s = 0; in0_tag = 4'd1; in0_valid = 1;
    in1_m = 48'h600000000000; in1_e = 9'd127; in1_s = 1; in1_tag = 4'd2; in1_valid = 1;
    got = 0; n = 0; ids = '0;
    while (got < 4 && n < 30) begin
      @(negedge clk);
      n++;
      if (out_valid) begin
        ids[got]  = out_id;
        tags[got] = out_tag;
        got++;
      end
    end
    chk("rr_count", got, 4);
    chk("rr_ids", ids, 4'b1010);
    chk("rr_tag0", tags[0], 4'd1);
    chk("rr_tag1", tags[1], 4'd2);
    chk("rr_tag2", tags[2], 4'd1);
    chk("rr_tag3", tags[3], 4'd2);

    // Output stall for three cycles with both requesters still valid
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    hz = out_z; ht = out_tag;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_z", out_z, hz);
      chk("hold_tag", out_tag, ht);
      chk("hold_rdy", {in0_ready, in1_ready}, 2'b00);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    in0_valid = 0; in1_valid = 0;
    repeat (6) @(negedge clk);
    chk("drain_directed", sb.size(), 0);

    // Randomized traffic with a reset pulse mid-stream
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      a0 = in0_valid && in0_ready;
      a1 = in1_valid && in1_ready;
      @(posedge clk); #1;
      rst = (c == 1500);
      if (!in0_valid || a0) begin
        in0_valid = ($urandom_range(0, 2) != 0);
        rand_op(in0_m, in0_e, in0_s);
        in0_tag = 4'($urandom);
      end
      if (!in1_valid || a1) begin
        in1_valid = ($urandom_range(0, 2) != 0);
        rand_op(in1_m, in1_e, in1_s);
        in1_tag = 4'($urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    in0_valid = 0; in1_valid = 0; out_ready = 1'b1;
    repeat (8) @(negedge clk);
    chk("drain_random", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
